led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
- Parametrised multi-channel LED pattern generator; next generation of the fixed 1 s three-LED toggler.
- Generalised in LED count, clock rate and step period; adds runtime-selectable patterns (blink, alternate, chase), enable/freeze, and a step strobe.
- Sits between the board clock and the LED pins in the lab top level.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 1000, base tick rate in Hz; DIV = CLK_HZ/TICK_HZ, must be integer and >= 2.
- NUM_LEDS, 3, LED channel count, >= 2.
- PERIOD_W, 16, width of the step-period input, in ticks.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = run; 0 = freeze LEDs and clear timing.
- mode  in  2  0 OFF, 1 BLINK, 2 ALT, 3 CHASE.
- period  in  PERIOD_W  step period in ticks; 0 is treated as 1.
- led  out  NUM_LEDS  LED drive, registered.
- step_pulse  out  1  one-cycle strobe in the cycle `led` updates on a step.

Behaviour:
- Reset (async assert, sync release):
  - led = 0, step_pulse = 0, prescaler = 0, step counter = 0.
  - mode_q = OFF, period_q = 1.
- Prescaler:
  - Runs while enable = 1, counting 0..DIV-1 and wrapping.
  - tick is internal and asserts combinationally when count == DIV-1 and enable = 1.
  - Held at 0 while enable = 0.
- Step counter:
  - Advances on tick, counting 0..period_q-1.
  - step = tick && step_cnt == period_q-1. On step the counter wraps to 0 and period_q is reloaded from period (0 maps to 1).
  - Period changes take effect only at a step boundary or on a restart.
- Restart: fires in any cycle where enable = 1 and either mode != mode_q or enable was 0 in the previous cycle. In that cycle:
  - mode_q <= mode, period_q <= max(period,1), prescaler <= 0, step counter <= 0.
  - led <= initial pattern of mode.
  - step_pulse = 0.
  - Restart has priority over a coincident step.
- Initial patterns:
  - OFF: all 0.
  - BLINK: all 1.
  - ALT: bit i = ~i[0], i.e. ...0101 with LSB = 1.
  - CHASE: one-hot, bit 0.
- On step (no restart): led updates in the same cycle and step_pulse = 1.
  - OFF: stays 0.
  - BLINK and ALT: led <= ~led.
  - CHASE: rotate left by 1, MSB wraps to bit 0.
- Step timing: first step occurs DIV*period_q cycles after restart; steps then repeat every DIV*period_q cycles.
- enable = 0:
  - led holds its last value; step_pulse = 0.
  - Counters cleared; mode/period changes ignored until re-enable.
- Counter widths:
  - Prescaler: clog2(DIV) bits.
  - Step counter: PERIOD_W bits.
  - Compares are exact; no overflow is possible.
- Reset asserted mid-pattern: immediate return to reset values; first restart occurs on the first clock after release with enable = 1, because mode_q = OFF mismatches any non-OFF mode.
  - If mode = OFF after release, no restart is needed; led stays 0.

Decomposition:
- Package led_pkg:
  - mode enum (MODE_OFF = 0, MODE_BLINK = 1, MODE_ALT = 2, MODE_CHASE = 3).
  - Function returning the initial pattern for (mode, NUM_LEDS).
- Sub-module tick_prescaler (params CLK_HZ, TICK_HZ):
  - Ports clk, rst_n, enable, clear, tick.
  - Reused by future debounce and timer blocks.
- Top holds mode_q, period_q, the step counter, the restart logic and the pattern register.

Test Plan (CLK_HZ = 1000, TICK_HZ = 100 so DIV = 10; NUM_LEDS = 4):
- Reset then BLINK: assert rst_n = 0, release with enable = 1, mode = BLINK, period = 3 -> led = 1111 one cycle after release; steps every 30 cycles: 0000, 1111, 0000; step_pulse high exactly in those cycles.
- CHASE wrap: mode = CHASE, period = 1 -> led sequence 0001, 0010, 0100, 1000, 0001, spaced 10 cycles apart.
- Mid-step mode change: ALT running (0101), switch to CHASE 5 cycles before a step -> led = 0001 next cycle, no step_pulse; next step 10*period cycles later.
- Period change: period changed from 2 to 5 mid-interval -> current interval still 20 cycles, following intervals 50 cycles; period = 0 -> 10-cycle intervals.
- Enable freeze: drop enable while led = 1010 for 37 cycles -> led holds 1010, step_pulse = 0; on re-enable led reloads to ALT initial 0101 and first step follows 10*period cycles later.
- Async reset mid-run: pulse rst_n low between clock edges -> led = 0000 immediately, without waiting for an edge; normal restart after release.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern generator family.
// Mode encoding and the per-mode starting pattern live here so other blocks agree on them.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_CHASE = 2'd3
  } mode_e;

  localparam int MAX_LEDS = 64;

  // Starting pattern of a mode for an n-wide LED bank; callers size-cast to their width.
  function automatic logic [MAX_LEDS-1:0] init_pattern(input mode_e m, input int n);
    logic [MAX_LEDS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      if (i < n) begin
        case (m)
          MODE_BLINK: p[i] = 1'b1;
          MODE_ALT:   p[i] = ((i % 2) == 0);
          MODE_CHASE: p[i] = (i == 0);
          default:    p[i] = 1'b0;
        endcase
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ/TICK_HZ cycles.
// Counting stops and the count is held at zero while disabled or cleared.
module tick_prescaler #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: blink, alternate and chase patterns stepped
// every `period` ticks, with freeze-on-disable and a strobe marking each step.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_LEDS = 3,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_pulse
);

  logic                tick;
  logic                restart;
  logic                step;
  logic                en_q;
  mode_e               mode_in;
  mode_e               mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_eff;
  logic [PERIOD_W-1:0] step_cnt;
  logic [NUM_LEDS-1:0] init_led;
  logic [NUM_LEDS-1:0] next_led;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .clear  (restart),
    .tick   (tick)
  );

  assign mode_in    = mode_e'(mode);
  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign restart    = enable && ((mode_in != mode_q) || !en_q);
  // A restart swallows a coincident step: the new pattern starts a fresh interval.
  assign step       = tick && (step_cnt == period_q - PERIOD_W'(1)) && !restart;
  assign init_led   = NUM_LEDS'(init_pattern(mode_in, NUM_LEDS));

  always_comb begin
    next_led = led;
    case (mode_q)
      MODE_OFF:   next_led = '0;
      MODE_BLINK: next_led = ~led;
      MODE_ALT:   next_led = ~led;
      MODE_CHASE: next_led = {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
      default:    next_led = led;
    endcase
  end

  // en_q resets high so reset release is not mistaken for a re-enable; the
  // OFF mode_q mismatch alone drives the first restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b1;
      mode_q   <= MODE_OFF;
      period_q <= PERIOD_W'(1);
      step_cnt <= '0;
    end else begin
      en_q <= enable;
      if (restart) begin
        mode_q   <= mode_in;
        period_q <= period_eff;
        step_cnt <= '0;
      end else if (!enable) begin
        step_cnt <= '0;
      end else if (step) begin
        period_q <= period_eff;
        step_cnt <= '0;
      end else if (tick) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led        <= '0;
      step_pulse <= 1'b0;
    end else if (restart) begin
      led        <= init_led;
      step_pulse <= 1'b0;
    end else if (step) begin
      led        <= next_led;
      step_pulse <= 1'b1;
    end else begin
      step_pulse <= 1'b0;
    end
  end

endmodule
